// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with frame-aligned double buffering.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        value_vld,
  output logic [3:0]  digit_bcd,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pflag_q, pflag_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             fd_q, fd_d;
  logic             tick;
  logic             boundary;
  logic [3:0]       blank_mask;

  function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'd0;
    endcase
    return n;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is dark when it and every more-significant nibble is zero; digit0 always lit.
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'd0);
    m[2] = m[3] && (v[11:8] == 4'd0);
    m[1] = m[2] && (v[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction
  assign blank_mask = lead_zero_mask(disp_q);
`else
  assign blank_mask = 4'b0000;
`endif

  assign tick     = (div_q == DIV_W'(REFRESH_DIV - 1));
  assign boundary = tick && (idx_q == 2'd3);

  // Next-state: refresh divider, slot index, buffer transfer and registered outputs.
  always_comb begin
    div_d   = div_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;

    if (tick) begin
      div_d = {DIV_W{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // A strobe landing on the boundary skips the buffer and goes straight to display.
    if (boundary) begin
      pflag_d = 1'b0;
      if (value_vld) begin
        disp_d = value_in;
      end else if (pflag_q) begin
        disp_d = pend_q;
      end else begin
        disp_d = disp_q;
      end
    end else if (value_vld) begin
      pend_d  = value_in;
      pflag_d = 1'b1;
    end else begin
      pend_d  = pend_q;
    end

    an_d  = ~(4'b0001 << idx_q) | blank_mask;
    bcd_d = nib_sel(disp_q, idx_q);
    fd_d  = boundary;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= {DIV_W{1'b0}};
      idx_q   <= 2'd0;
      disp_q  <= 16'd0;
      pend_q  <= 16'd0;
      pflag_q <= 1'b0;
      an_q    <= 4'b1111;
      bcd_q   <= 4'd0;
      fd_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
      fd_q    <= fd_d;
    end
  end

  assign digit_bcd  = bcd_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule
